// File: rtl/sr_video_pkg.sv
// ---------------------------------------------------------------------------
// sr_video_pkg
// Shared video definitions for the frame-buffer read and write controllers:
//   - RGB444_W        : stored pixel width (RGB444)
//   - SRC_H_DEFAULT / SRC_V_DEFAULT : default stored image geometry
//   - rd_state_e      : readout controller FSM states
//   - rgb444_to_888() : nibble-replicating colour expansion
// ---------------------------------------------------------------------------
package sr_video_pkg;

    localparam int RGB444_W      = 12;
    localparam int SRC_H_DEFAULT = 512;
    localparam int SRC_V_DEFAULT = 384;

    typedef enum logic [1:0] {
        S_NOFRAME = 2'd0,
        S_ARMED   = 2'd1,
        S_ACTIVE  = 2'd2
    } rd_state_e;

    // Replicating each nibble maps 4'hF to 8'hFF exactly, so full-scale
    // stays full-scale.
    function automatic logic [23:0] rgb444_to_888(input logic [RGB444_W-1:0] p);
        return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
    endfunction

endpackage

// File: rtl/sr_frame_readout_ctrl_if.sv
// ---------------------------------------------------------------------------
// sr_frame_readout_ctrl_if
// Frame-buffer BRAM read port (port B).
//   rd_en   : read enable        (controller -> BRAM)
//   rd_addr : read address       (controller -> BRAM)
//   rd_data : RGB444 read data, valid one cycle after rd_en (BRAM -> controller)
// Modports: master = readout controller, slave = BRAM.
// ---------------------------------------------------------------------------
interface sr_frame_readout_ctrl_if
    import sr_video_pkg::*;
#(
    parameter int ADDR_W = 18
) ();

    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [RGB444_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input  rd_data);
    modport slave  (input  rd_en, input  rd_addr, output rd_data);

endinterface

// File: rtl/sr_sync_delay.sv
// ---------------------------------------------------------------------------
// sr_sync_delay
// Fixed-depth shift register used to align the display sync/enable bits with
// the BRAM read pipeline.
//   i_clk  : clock
//   i_rstn : asynchronous active-low reset (clears every stage)
//   i_d    : WIDTH-bit input
//   o_d    : i_d delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module sr_sync_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign o_d = pipe_q[DEPTH-1];

endmodule

// File: rtl/sr_frame_readout_ctrl.sv
// ---------------------------------------------------------------------------
// sr_frame_readout_ctrl
// Pixel-domain sequencer for the frame-buffer BRAM read port. Generates read
// addresses from display timing with 2^SCALE_SHIFT integer upscaling of a
// SRC_H x SRC_V RGB444 image, holds the display black until a complete
// camera frame has been written, and re-aligns vde/hsync/vsync to the
// 3-cycle read pipeline.
//
// Ports:
//   i_clk_pixel, i_rstn        : pixel clock, async active-low reset
//   i_frame_done               : 1-cycle pulse, writer finished a frame
//   i_vde, i_hsync, i_vsync    : display timing inputs
//   bram (master)              : BRAM port B (rd_en, rd_addr, rd_data)
//   o_video_data               : RGB888 pixel
//   o_video_vde/hsync/vsync    : timing delayed by 3 cycles
//   o_frame_start              : pulse the cycle after an i_vsync rise
//   o_frame_valid              : high while displaying a written frame
//
// Build option: SR_READOUT_PATTERN_EN -- when defined, the active window
// shows 8 vertical colour bars while no frame has been written yet.
// ---------------------------------------------------------------------------
module sr_frame_readout_ctrl
    import sr_video_pkg::*;
#(
    parameter int SRC_H       = SRC_H_DEFAULT,
    parameter int SRC_V       = SRC_V_DEFAULT,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 18
) (
    input  logic                    i_clk_pixel,
    input  logic                    i_rstn,
    input  logic                    i_frame_done,
    input  logic                    i_vde,
    input  logic                    i_hsync,
    input  logic                    i_vsync,
    sr_frame_readout_ctrl_if.master bram,
    output logic [23:0]             o_video_data,
    output logic                    o_video_vde,
    output logic                    o_video_hsync,
    output logic                    o_video_vsync,
    output logic                    o_frame_start,
    output logic                    o_frame_valid
);

    localparam int                CNT_W     = 12;
    localparam logic [CNT_W-1:0]  WIN_H     = CNT_W'(SRC_H << SCALE_SHIFT);
    localparam logic [CNT_W-1:0]  WIN_V     = CNT_W'(SRC_V << SCALE_SHIFT);
    localparam logic [CNT_W-1:0]  LN_MASK   = CNT_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_H);

    rd_state_e          state_q, state_d;
    logic               vsync_q, vde_q, frame_start_q;
    logic [CNT_W-1:0]   px_cnt_q, px_cnt_d;
    logic [CNT_W-1:0]   ln_cnt_q, ln_cnt_d;
    logic [CNT_W-1:0]   ln_next;
    logic [ADDR_W-1:0]  line_base_q, line_base_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_en_q, rd_en_s2_q;
    logic [23:0]        video_data_q, video_data_d;
    logic               vs_rise, vde_fall, in_window, rd_win;
    logic [2:0]         sync_dly;

    assign vs_rise   = i_vsync & ~vsync_q;
    assign vde_fall  = ~i_vde & vde_q;
    assign ln_next   = ln_cnt_q + 1'b1;
    // Geometry part of the window; the FSM state decides BRAM vs. pattern.
    assign in_window = i_vde && (px_cnt_q < WIN_H) && (ln_cnt_q < WIN_V);
    assign rd_win    = in_window && (state_q == S_ACTIVE);

    // FSM: a frame_done coincident with the frame-start cycle is treated as
    // having arrived first, so that very frame is displayed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NOFRAME: if (i_frame_done) state_d = vs_rise ? S_ACTIVE : S_ARMED;
            S_ARMED:   if (vs_rise)      state_d = S_ACTIVE;
            S_ACTIVE:  state_d = S_ACTIVE;
            default:   state_d = S_NOFRAME;
        endcase
    end

    // Raster counters; line_base advances once every 2^SCALE_SHIFT lines so
    // each stored line is repeated vertically.
    always_comb begin
        px_cnt_d    = px_cnt_q;
        ln_cnt_d    = ln_cnt_q;
        line_base_d = line_base_q;
        if (i_vde)         px_cnt_d = px_cnt_q + 1'b1;
        else if (vde_fall) px_cnt_d = '0;
        if (vs_rise) begin
            ln_cnt_d    = '0;
            line_base_d = '0;
        end else if (vde_fall) begin
            ln_cnt_d = ln_next;
            if ((ln_next & LN_MASK) == '0) line_base_d = line_base_q + LINE_STEP;
        end
    end

    assign rd_addr_d = rd_win ? line_base_q + ADDR_W'(px_cnt_q >> SCALE_SHIFT)
                              : rd_addr_q;

    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= S_NOFRAME;
            vsync_q       <= 1'b0;
            vde_q         <= 1'b0;
            frame_start_q <= 1'b0;
            px_cnt_q      <= '0;
            ln_cnt_q      <= '0;
            line_base_q   <= '0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= i_vsync;
            vde_q         <= i_vde;
            frame_start_q <= vs_rise;
            px_cnt_q      <= px_cnt_d;
            ln_cnt_q      <= ln_cnt_d;
            line_base_q   <= line_base_d;
        end
    end

    // Stage 1: read request to BRAM. Stage 2: BRAM output register.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_en_s2_q <= 1'b0;
        end else begin
            rd_en_q    <= rd_win;
            rd_addr_q  <= rd_addr_d;
            rd_en_s2_q <= rd_en_q;
        end
    end

`ifdef SR_READOUT_PATTERN_EN
    logic       pat_vld_s1_q, pat_vld_s2_q;
    logic [2:0] pat_bar_s1_q, pat_bar_s2_q;

    // Pattern travels alongside the read pipeline to match its latency.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            pat_vld_s1_q <= 1'b0;
            pat_vld_s2_q <= 1'b0;
            pat_bar_s1_q <= '0;
            pat_bar_s2_q <= '0;
        end else begin
            pat_vld_s1_q <= in_window && (state_q != S_ACTIVE);
            pat_vld_s2_q <= pat_vld_s1_q;
            pat_bar_s1_q <= px_cnt_q[9:7];
            pat_bar_s2_q <= pat_bar_s1_q;
        end
    end
`endif

    always_comb begin
        video_data_d = '0;
        if (rd_en_s2_q) begin
            video_data_d = rgb444_to_888(bram.rd_data);
        end
`ifdef SR_READOUT_PATTERN_EN
        else if (pat_vld_s2_q) begin
            video_data_d = {{8{pat_bar_s2_q[2]}}, {8{pat_bar_s2_q[1]}}, {8{pat_bar_s2_q[0]}}};
        end
`endif
    end

    // Stage 3: output pixel register.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) video_data_q <= '0;
        else         video_data_q <= video_data_d;
    end

    sr_sync_delay #(
        .DEPTH (3),
        .WIDTH (3)
    ) u_sync_delay (
        .i_clk  (i_clk_pixel),
        .i_rstn (i_rstn),
        .i_d    ({i_vde, i_hsync, i_vsync}),
        .o_d    (sync_dly)
    );

    assign bram.rd_en    = rd_en_q;
    assign bram.rd_addr  = rd_addr_q;
    assign o_video_data  = video_data_q;
    assign o_video_vde   = sync_dly[2];
    assign o_video_hsync = sync_dly[1];
    assign o_video_vsync = sync_dly[0];
    assign o_frame_start = frame_start_q;
    assign o_frame_valid = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_sr_frame_readout_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_frame_readout_ctrl
// Directed bench for sr_frame_readout_ctrl (512x384 source, 2x upscale).
// ---------------------------------------------------------------------------
module tb_sr_frame_readout_ctrl;
    import sr_video_pkg::*;

    localparam int ADDR_W = 18;

    logic        clk = 1'b0;
    logic        rstn, fd, vde, hs, vs;
    logic [23:0] vdata;
    logic        vvde, vhs, vvs, fstart, fvalid;
    int          n_chk = 0;
    int          n_err = 0;

    sr_frame_readout_ctrl_if #(.ADDR_W(ADDR_W)) bram_if();

    sr_frame_readout_ctrl #(
        .SRC_H       (512),
        .SRC_V       (384),
        .SCALE_SHIFT (1),
        .ADDR_W      (ADDR_W)
    ) dut (
        .i_clk_pixel   (clk),
        .i_rstn        (rstn),
        .i_frame_done  (fd),
        .i_vde         (vde),
        .i_hsync       (hs),
        .i_vsync       (vs),
        .bram          (bram_if.master),
        .o_video_data  (vdata),
        .o_video_vde   (vvde),
        .o_video_hsync (vhs),
        .o_video_vsync (vvs),
        .o_frame_start (fstart),
        .o_frame_valid (fvalid)
    );

    always #5 clk = ~clk;

    // BRAM content: address 5 holds 12'hF80, elsewhere low address bits ^ 5A5.
    function automatic logic [11:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [11:0] lo;
        lo = a[11:0];
        return (a == 18'd5) ? 12'hF80 : (lo ^ 12'h5A5);
    endfunction

    always @(posedge clk) begin
        if (bram_if.rd_en) bram_if.rd_data <= mem_word(bram_if.rd_addr);
    end

    typedef struct {
        logic        vde, vs, fd;
        logic        en;
        logic [17:0] addr;
        logic        fs, fv;
    } vec_t;

    vec_t tbl [21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic frame_start();
        vs = 1'b1;
        step();
        check("frame_start_pulse", {31'd0, fstart}, 32'd1);
        step();
        vs = 1'b0;
        step();
    endtask

    // One 16-pixel line starting at pixel 0; active selects BRAM-driven output.
    task automatic line_seq(input logic active, input string tag);
        for (int j = 0; j < 20; j++) begin
            vde = (j < 16);
            hs  = (j == 16);
            step();
            check($sformatf("%s.rd_en%0d", tag, j), {31'd0, bram_if.rd_en},
                  {31'd0, active && (j < 16)});
            check($sformatf("%s.vvde%0d", tag, j), {31'd0, vvde},
                  {31'd0, (j >= 2) && (j <= 17)});
            if (j == 18) check($sformatf("%s.vhs", tag), {31'd0, vhs}, 32'd1);
            if (j == 1)  check($sformatf("%s.data1", tag), {8'd0, vdata}, 32'd0);
            if (j == 2)  check($sformatf("%s.data_px0", tag), {8'd0, vdata},
                               active ? 32'h0055AA55 : 32'd0);
            if (j == 12) check($sformatf("%s.data_addr5", tag), {8'd0, vdata},
                               active ? 32'h00FF8800 : 32'd0);
            if (j == 19) check($sformatf("%s.data_end", tag), {8'd0, vdata}, 32'd0);
        end
        hs = 1'b0;
    endtask

    initial begin
        // Each row: inputs before the edge, then registered outputs after it.
        //          vde   vs    fd    en    addr      fs    fv
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 18'd0,   1'b1, 1'b0};  // frame start, no frame yet
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 18'd0,   1'b0, 1'b0};  // frame_done mid-frame
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 18'd0,   1'b1, 1'b1};  // armed -> active
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd0,   1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd0,   1'b0, 1'b1};  // line 0
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd0,   1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd1,   1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd1,   1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd1,   1'b0, 1'b1};  // address holds
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd0,   1'b0, 1'b1};  // line 1 repeats line 0
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd0,   1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd1,   1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd1,   1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd512, 1'b0, 1'b1};  // line 2
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd512, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'd513, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'd513, 1'b0, 1'b1};

        rstn = 1'b0; fd = 1'b0; vde = 1'b0; hs = 1'b0; vs = 1'b0;
        step();
        step();
        check("rst.rd_en",  {31'd0, bram_if.rd_en}, 32'd0);
        check("rst.addr",   {14'd0, bram_if.rd_addr}, 32'd0);
        check("rst.data",   {8'd0, vdata}, 32'd0);
        check("rst.vvde",   {31'd0, vvde}, 32'd0);
        check("rst.fstart", {31'd0, fstart}, 32'd0);
        check("rst.fvalid", {31'd0, fvalid}, 32'd0);
        rstn = 1'b1;
        step();

        // No frame written: no reads, black output, sync delayed by 3.
        line_seq(1'b0, "noframe");
        check("noframe.fvalid", {31'd0, fvalid}, 32'd0);

        for (int i = 0; i < 21; i++) begin
            vde = tbl[i].vde;
            vs  = tbl[i].vs;
            fd  = tbl[i].fd;
            step();
            check($sformatf("tbl%0d.en", i),   {31'd0, bram_if.rd_en}, {31'd0, tbl[i].en});
            check($sformatf("tbl%0d.addr", i), {14'd0, bram_if.rd_addr}, {14'd0, tbl[i].addr});
            check($sformatf("tbl%0d.fs", i),   {31'd0, fstart}, {31'd0, tbl[i].fs});
            check($sformatf("tbl%0d.fv", i),   {31'd0, fvalid}, {31'd0, tbl[i].fv});
        end
        fd = 1'b0;

        // Data path: px0 -> addr 0 -> 55AA55, px10 -> addr 5 -> FF8800.
        frame_start();
        line_seq(1'b1, "active");
        step();

        // Full frame: 767 one-pixel lines, then the last window line.
        frame_start();
        for (int ln = 0; ln < 767; ln++) begin
            vde = 1'b1; step();
            vde = 1'b0; step();
        end
        for (int k = 0; k < 1025; k++) begin
            vde = 1'b1;
            step();
            if (k == 0) check("last_line.first_addr", {14'd0, bram_if.rd_addr}, 32'd196096);
            if (k == 1023) begin
                check("last_line.final_en",   {31'd0, bram_if.rd_en}, 32'd1);
                check("last_line.final_addr", {14'd0, bram_if.rd_addr}, 32'd196607);
            end
            if (k == 1024) begin
                check("right_edge.en",   {31'd0, bram_if.rd_en}, 32'd0);
                check("right_edge.addr", {14'd0, bram_if.rd_addr}, 32'd196607);
            end
        end
        vde = 1'b0; step();
        vde = 1'b1; step();
        check("bottom_edge.en", {31'd0, bram_if.rd_en}, 32'd0);
        vde = 1'b0; step();

        // Reset in the middle of an active line.
        frame_start();
        vde = 1'b1;
        step(); step(); step();
        check("pre_rst.en", {31'd0, bram_if.rd_en}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("midrst.en",     {31'd0, bram_if.rd_en}, 32'd0);
        check("midrst.addr",   {14'd0, bram_if.rd_addr}, 32'd0);
        check("midrst.data",   {8'd0, vdata}, 32'd0);
        check("midrst.vvde",   {31'd0, vvde}, 32'd0);
        check("midrst.fvalid", {31'd0, fvalid}, 32'd0);
        #1 rstn = 1'b1;
        vde = 1'b0;
        step();
        frame_start();
        vde = 1'b1; step();
        check("after_rst.en", {31'd0, bram_if.rd_en}, 32'd0);
        check("after_rst.fv", {31'd0, fvalid}, 32'd0);
        vde = 1'b0; step();

        // frame_done on the same cycle the vsync edge is sampled.
        vs = 1'b1; fd = 1'b1;
        step();
        check("coincident.fv", {31'd0, fvalid}, 32'd1);
        check("coincident.fs", {31'd0, fstart}, 32'd1);
        fd = 1'b0;
        step();
        vs = 1'b0;
        step();
        vde = 1'b1;
        step();
        check("coincident.en",   {31'd0, bram_if.rd_en}, 32'd1);
        check("coincident.addr", {14'd0, bram_if.rd_addr}, 32'd0);
        vde = 1'b0;
        step();

`ifdef SR_READOUT_PATTERN_EN
        // Colour bars while no frame has been written.
        rstn = 1'b0; step();
        rstn = 1'b1; step();
        frame_start();
        for (int j = 0; j < 1026; j++) begin
            vde = (j < 1024);
            step();
            if (j == 2)    check("pat.px0",    {8'd0, vdata}, 32'h00000000);
            if (j == 129)  check("pat.px127",  {8'd0, vdata}, 32'h00000000);
            if (j == 130)  check("pat.px128",  {8'd0, vdata}, 32'h000000FF);
            if (j == 902)  check("pat.px900",  {8'd0, vdata}, 32'h00FFFFFF);
            if (j == 1025) check("pat.px1023", {8'd0, vdata}, 32'h00FFFFFF);
        end
        vde = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
